dsp_preadd_mult: RTL and testbench

Pre-adder/multiplier stage of the DSP48A1 slice. It sits directly downstream of the A/B/D input register-mux stages and consumes their 18-bit outputs. It forms D±B (or passes B), registers it as the B1 value, multiplies it by A (signed 18x18), and registers the 36-bit product for the post-adder/accumulator stage. A valid bit travels alongside the data so downstream logic knows when the product is meaningful.

---
 rtl/dsp_preadd_mult.sv | 158 +++++++++++++++
 tb/tb_dsp_preadd_mult.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_preadd_mult.sv
`default_nettype none
// ============================================================================
// Module   : dsp_preadd_mult
// Purpose  : Pre-adder / multiplier stage of a DSP48A1-style slice.
//            Forms D+B, D-B or B, optionally registers it as the B1 value
//            (with A and a valid bit aligned alongside). It then forms the
//            signed WIDTHxWIDTH product and optionally registers it as the
//            M value for the post-adder.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  operand width of A, B, D (product is 2*WIDTH)
//   B1REG  1 = register pre-adder result, 0 = combinational pass
//   MREG   1 = register multiplier output, 0 = combinational pass
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (clears all registers)
//   a_in        signed multiplicand
//   b_in        B operand
//   d_in        D operand (pre-adder only)
//   opmode_pre  bit1 = use pre-adder, bit0 = subtract (D-B)
//   in_valid    inputs valid this cycle
//   ce_b1       clock enable, B1 stage (B1 value, aligned A, valid)
//   ce_m        clock enable, M stage (product, valid)
//   b1_out      B1 value (BCOUT cascade)
//   m_out       signed 2*WIDTH product
//   out_valid   m_out valid
// Build option
//   DSP_PREADD_EN  defined   : pre-adder present
//                  undefined : pre = b_in; d_in and opmode_pre ignored
// ============================================================================
module dsp_preadd_mult #(
  parameter int WIDTH = 18,
  parameter int B1REG = 1,
  parameter int MREG  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [WIDTH-1:0]     d_in,
  input  logic [1:0]           opmode_pre,
  input  logic                 in_valid,
  input  logic                 ce_b1,
  input  logic                 ce_m,
  output logic [WIDTH-1:0]     b1_out,
  output logic [2*WIDTH-1:0]   m_out,
  output logic                 out_valid
);

  logic [WIDTH-1:0]   w_pre;
  logic [WIDTH-1:0]   w_b1;
  logic [WIDTH-1:0]   w_a1;
  logic               w_v1;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_m;
  logic               w_vm;

  // --------------------------------------------------------------------------
  // Pre-adder: modulo 2^WIDTH, carry-out discarded
  // --------------------------------------------------------------------------
`ifdef DSP_PREADD_EN
  always_comb begin
    w_pre = b_in;
    if (opmode_pre[1]) begin
      w_pre = opmode_pre[0] ? (d_in - b_in) : (d_in + b_in);
    end
  end
`else
  assign w_pre = b_in;

  logic w_unused_preadd;
  assign w_unused_preadd = ^{d_in, opmode_pre};
`endif

  // --------------------------------------------------------------------------
  // B1 stage. A disabled stage holds (it does not zero like the input stages),
  // so a stalled item is presented again to the M stage.
  // --------------------------------------------------------------------------
  generate
    if (B1REG != 0) begin : g_b1_reg
      logic [WIDTH-1:0] r_b1;
      logic [WIDTH-1:0] r_a1;
      logic             r_v1;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_b1 <= '0;
          r_a1 <= '0;
          r_v1 <= 1'b0;
        end else if (ce_b1) begin
          r_b1 <= w_pre;
          r_a1 <= a_in;
          r_v1 <= in_valid;
        end
      end

      assign w_b1 = r_b1;
      assign w_a1 = r_a1;
      assign w_v1 = r_v1;
    end else begin : g_b1_comb
      assign w_b1 = w_pre;
      assign w_a1 = a_in;
      assign w_v1 = in_valid;

      logic w_unused_ce_b1;
      assign w_unused_ce_b1 = ce_b1;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Multiplier: operands sign-extended to the full product width so the
  // 2*WIDTH result is the exact signed product.
  // --------------------------------------------------------------------------
  assign w_prod = $signed({{WIDTH{w_a1[WIDTH-1]}}, w_a1}) *
                  $signed({{WIDTH{w_b1[WIDTH-1]}}, w_b1});

  // --------------------------------------------------------------------------
  // M stage
  // --------------------------------------------------------------------------
  generate
    if (MREG != 0) begin : g_m_reg
      logic [2*WIDTH-1:0] r_m;
      logic               r_vm;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_m  <= '0;
          r_vm <= 1'b0;
        end else if (ce_m) begin
          r_m  <= w_prod;
          r_vm <= w_v1;
        end
      end

      assign w_m  = r_m;
      assign w_vm = r_vm;
    end else begin : g_m_comb
      assign w_m  = w_prod;
      assign w_vm = w_v1;

      logic w_unused_ce_m;
      assign w_unused_ce_m = ce_m;
    end

    // Fully combinational build has no clocked logic at all.
    if ((B1REG == 0) && (MREG == 0)) begin : g_no_regs
      logic w_unused_clk;
      assign w_unused_clk = clk ^ rst;
    end
  endgenerate

  assign b1_out    = w_b1;
  assign m_out     = w_m;
  assign out_valid = w_vm;

endmodule
`default_nettype wire

// File: tb/tb_dsp_preadd_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_preadd_mult
// Purpose  : Self-checking bench for dsp_preadd_mult. A registered instance
//            (B1REG=MREG=1) and a fully combinational instance share inputs.
//            A behavioural model (items moving through two enabled slots,
//            products formed with 64-bit integer arithmetic) is checked every
//            cycle; hand-computed literals pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_preadd_mult;

  localparam int W = 18;
`ifdef DSP_PREADD_EN
  localparam bit PREADD = 1'b1;
`else
  localparam bit PREADD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a_in, b_in, d_in;
  logic [1:0]     opmode_pre;
  logic           in_valid, ce_b1, ce_m;
  logic [W-1:0]   b1_out, b1_c;
  logic [2*W-1:0] m_out, m_c;
  logic           out_valid, v_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp_preadd_mult #(.WIDTH(W), .B1REG(1), .MREG(1)) u_dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .d_in(d_in),
    .opmode_pre(opmode_pre), .in_valid(in_valid), .ce_b1(ce_b1), .ce_m(ce_m),
    .b1_out(b1_out), .m_out(m_out), .out_valid(out_valid)
  );

  dsp_preadd_mult #(.WIDTH(W), .B1REG(0), .MREG(0)) u_comb (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .d_in(d_in),
    .opmode_pre(opmode_pre), .in_valid(in_valid), .ce_b1(ce_b1), .ce_m(ce_m),
    .b1_out(b1_c), .m_out(m_c), .out_valid(v_c)
  );

  // ---------------- model ----------------
  function automatic logic [W-1:0] f_pre(input logic [W-1:0] b, input logic [W-1:0] d,
                                         input logic [1:0] op);
    if (PREADD && op[1]) return op[0] ? W'(d - b) : W'(d + b);
    return b;
  endfunction

  function automatic logic [2*W-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] p);
    longint sa, sp;
    sa = longint'($signed(a));
    sp = longint'($signed(p));
    return (2*W)'(sa * sp);
  endfunction

  // Slot 1 holds the item after the pre-adder, slot 2 the finished product.
  logic [W-1:0]   s1_pre, s1_a;
  logic           s1_v;
  logic [2*W-1:0] s2_m;
  logic           s2_v;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_pre = '0; s1_a = '0; s1_v = 1'b0; s2_m = '0; s2_v = 1'b0;
    end else begin
      if (ce_m) begin
        s2_m = f_mul(s1_a, s1_pre);
        s2_v = s1_v;
      end
      if (ce_b1) begin
        s1_pre = f_pre(b_in, d_in, opmode_pre);
        s1_a   = a_in;
        s1_v   = in_valid;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, 2 time units after the active edge.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      chk("model_b1", 64'(b1_out), 64'(s1_pre));
      chk("model_m", 64'(m_out), 64'(s2_m));
      chk("model_v", 64'(out_valid), 64'(s2_v));
      chk("comb_b1", 64'(b1_c), 64'(f_pre(b_in, d_in, opmode_pre)));
      chk("comb_m", 64'(m_c), 64'(f_mul(a_in, f_pre(b_in, d_in, opmode_pre))));
      chk("comb_v", 64'(v_c), 64'(in_valid));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] d, input logic [1:0] op);
    @(negedge clk);
    in_valid = v; a_in = a; b_in = b; d_in = d; opmode_pre = op;
  endtask

  // One item through the registered pipe, with literal checks on both stages
  // and on the combinational instance in the same cycle.
  task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic [1:0] op,
                         input logic [W-1:0] eb1, input logic [2*W-1:0] em);
    drive(1'b1, a, b, d, op);
    #1;
    chk({name, "_comb_m"}, 64'(m_c), 64'(em));
    @(posedge clk); #2;
    chk({name, "_b1"}, 64'(b1_out), 64'(eb1));
    drive(1'b0, '0, '0, '0, 2'b00);
    @(posedge clk); #2;
    chk({name, "_m"}, 64'(m_out), 64'(em));
    chk({name, "_v"}, 64'(out_valid), 64'd1);
  endtask

  typedef struct { logic ceb; logic cem; logic [W-1:0] a; logic [W-1:0] b; } vec_t;
  vec_t ce_tab[8];

  initial begin
    rst = 1'b0; ce_b1 = 1'b1; ce_m = 1'b1;
    in_valid = 1'b1; a_in = 18'd5; b_in = 18'd6; d_in = 18'd7; opmode_pre = 2'b10;

    // Reset held with live inputs
    repeat (3) @(negedge clk);
    #1;
    chk("rst_b1", 64'(b1_out), 64'd0);
    chk("rst_m", 64'(m_out), 64'd0);
    chk("rst_v", 64'(out_valid), 64'd0);

    // Release; first valid output exactly 2 edges later
    @(negedge clk);
    rst = 1'b1; a_in = 18'd3; b_in = 18'd5; d_in = 18'd0; opmode_pre = 2'b00;
    @(posedge clk); #2;
    chk("lat_edge1_v", 64'(out_valid), 64'd0);
    drive(1'b0, '0, '0, '0, 2'b00);
    @(posedge clk); #2;
    chk("lat_edge2_v", 64'(out_valid), 64'd1);
    chk("lat_edge2_m", 64'(m_out), 64'd15);
    repeat (2) @(posedge clk);

    // Add / sub / bypass, signed, wrap, extreme product
    run_one("add", 18'd3, 18'd5, 18'd10, 2'b10, PREADD ? 18'd15 : 18'd5,
            PREADD ? 36'd45 : 36'd15);
    run_one("sub", 18'd3, 18'd5, 18'd10, 2'b11, 18'd5, 36'd15);
    run_one("byp", 18'd3, 18'd5, 18'd10, 2'b00, 18'd5, 36'd15);
    run_one("neg", 18'h3FFFF, 18'd7, 18'd0, 2'b00, 18'd7, 36'hFFFFFFFF9);
    run_one("wrap", 18'd3, 18'd1, 18'h1FFFF, 2'b10, PREADD ? 18'h20000 : 18'd1,
            PREADD ? 36'hFFFFA0000 : 36'd3);
    run_one("minmin", 18'h20000, 18'h20000, 18'd0, 2'b00, 18'h20000, 36'h400000000);

    // Stall B1 for two cycles after item 2; products 10,40,90,160
    drive(1'b1, 18'd1, 18'd10, 18'd0, 2'b00);
    drive(1'b1, 18'd2, 18'd20, 18'd0, 2'b00);
    drive(1'b1, 18'd3, 18'd30, 18'd0, 2'b00);
    ce_b1 = 1'b0;
    @(posedge clk); #2;
    chk("stall_c1_m", 64'(m_out), 64'd40);
    chk("stall_c1_v", 64'(out_valid), 64'd1);
    @(posedge clk); #2;
    chk("stall_c2_m", 64'(m_out), 64'd40);
    @(negedge clk); ce_b1 = 1'b1;
    @(posedge clk); #2;
    chk("stall_c3_m", 64'(m_out), 64'd40);
    drive(1'b1, 18'd4, 18'd40, 18'd0, 2'b00);
    @(posedge clk); #2;
    chk("stall_it3_m", 64'(m_out), 64'd90);
    drive(1'b0, '0, '0, '0, 2'b00);
    @(posedge clk); #2;
    chk("stall_it4_m", 64'(m_out), 64'd160);
    chk("stall_it4_v", 64'(out_valid), 64'd1);
    repeat (2) @(posedge clk);

    // Mixed enable patterns, checked by the model
    ce_tab = '{'{1, 1, 18'd7, 18'd9}, '{1, 0, 18'h3FFF0, 18'd33}, '{0, 1, 18'd5, 18'd5},
               '{1, 1, 18'd11, 18'h3FFFE}, '{0, 0, 18'd2, 18'd2}, '{1, 0, 18'd100, 18'd200},
               '{1, 1, 18'h1FFFF, 18'h1FFFF}, '{0, 1, 18'd1, 18'd1}};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ce_tab[i].a, ce_tab[i].b, 18'(i * 3), 2'(i));
      ce_b1 = ce_tab[i].ceb; ce_m = ce_tab[i].cem;
    end
    drive(1'b0, '0, '0, '0, 2'b00);
    ce_b1 = 1'b1; ce_m = 1'b1;
    repeat (3) @(posedge clk);

    // Reset mid-flight with two items in the pipe
    drive(1'b1, 18'd6, 18'd7, 18'd0, 2'b00);
    drive(1'b1, 18'd8, 18'd9, 18'd0, 2'b00);
    @(posedge clk); #2;
    chk("pre_rst_v", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; a_in = '0; b_in = '0;
    #1 rst = 1'b0;
    #1;
    chk("midrst_v", 64'(out_valid), 64'd0);
    chk("midrst_m", 64'(m_out), 64'd0);
    chk("midrst_b1", 64'(b1_out), 64'd0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("post_rst_v", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
